// File: rtl/uart_chan_arbiter.sv
// Round-robin arbiter sharing one UART channel register port between two requesters.
// Latches the winning request, runs one channel access at a time, and reports completion, read data or timeout.
module uart_chan_arbiter #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ch_req,
    output logic              ch_write,
    output logic              ch_read,
    output logic [ADDR_W-1:0] ch_addr,
    output logic [DATA_W-1:0] ch_wdata,
    input  logic [DATA_W-1:0] ch_rdata,
    input  logic              ch_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant;
    logic              winner;
    logic              any_req;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [15:0]       cnt;
    logic [DATA_W-1:0] res_rdata;
    logic              res_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        any_req    = m0_req | m1_req;
        winner     = (m0_req & m1_req) ? ~last_grant : m1_req;
        state_next = state;
        ch_req     = 1'b0;
        ch_write   = 1'b0;
        ch_read    = 1'b0;
        ch_addr    = lat_addr;
        ch_wdata   = lat_wdata;
        busy       = 1'b0;
        m0_done    = 1'b0;
        m0_err     = 1'b0;
        m0_rdata   = '0;
        m1_done    = 1'b0;
        m1_err     = 1'b0;
        m1_rdata   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy     = 1'b1;
                ch_req   = 1'b1;
                ch_write = lat_write;
                ch_read  = ~lat_write;
                if (ch_ready || (cnt == CNT_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
                if (grant) begin
                    m1_done  = 1'b1;
                    m1_err   = res_err;
                    m1_rdata = res_rdata;
                end else begin
                    m0_done  = 1'b1;
                    m0_err   = res_err;
                    m0_rdata = res_rdata;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured once at grant so the requester may change them mid-access.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            res_rdata  <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        grant <= winner;
                        if (winner) begin
                            lat_write <= m1_write;
                            lat_addr  <= m1_addr;
                            lat_wdata <= m1_wdata;
                        end else begin
                            lat_write <= m0_write;
                            lat_addr  <= m0_addr;
                            lat_wdata <= m0_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (ch_ready) begin
                        res_rdata <= lat_write ? '0 : ch_rdata;
                        res_err   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        res_rdata <= '0;
                        res_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    last_grant <= grant;
                    cnt        <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_chan_arbiter.sv
// Bench for uart_chan_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// The channel is emulated by a responder that answers after a chosen number of ISSUE cycles.
module tb_uart_chan_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_write = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_done, m0_err;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_write = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_done, m1_err;
    logic [DW-1:0] m1_rdata;
    logic          ch_req, ch_write, ch_read;
    logic [AW-1:0] ch_addr;
    logic [DW-1:0] ch_wdata;
    logic [DW-1:0] ch_rdata = '0;
    logic          ch_ready = 1'b0;
    logic          busy;

    int total = 0;
    int bad = 0;

    int            force_delay = 0;
    bit            force_data_en = 0;
    logic [DW-1:0] force_data = '0;
    bit            noise = 0;
    int            chan_cnt = 0;
    int            chan_delay = 0;
    logic [DW-1:0] chan_data = '0;

    uart_chan_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ch_req(ch_req), .ch_write(ch_write), .ch_read(ch_read),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata), .ch_ready(ch_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Channel model: answers on ISSUE cycle chan_delay+1 (0-based count chan_delay); a negative force picks randomly.
    always @(negedge clk) begin
        if (ch_req) begin
            if (chan_cnt == 0) begin
                chan_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 5));
                chan_data  = force_data_en ? force_data : $urandom;
            end
            ch_ready = (chan_cnt == chan_delay);
            ch_rdata = (chan_cnt == chan_delay) ? chan_data : $urandom;
            chan_cnt++;
        end else begin
            chan_cnt = 0;
            ch_ready = noise ? 1'($urandom) : 1'b0;
            ch_rdata = $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({ch_req, ch_write, ch_read, ch_addr, ch_wdata, busy} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_ch: got req=%b wr=%b rd=%b addr=%h wdata=%h busy=%b, want all 0",
                     ch_req, ch_write, ch_read, ch_addr, ch_wdata, busy);
        end
        total++;
        if ({m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_m: got d0=%b e0=%b r0=%h d1=%b e1=%b r1=%h, want all 0",
                     m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata);
        end
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_single_write();
        force_delay = 0;
        force_data_en = 0;
        m0_write = 1'b1;
        m0_addr  = 4'h4;
        m0_wdata = 32'h55;
        m0_req   = 1'b1;
        tick();
        total++;
        if ({ch_req, ch_write, ch_read, ch_addr, ch_wdata} !== {1'b1, 1'b1, 1'b0, 4'h4, 32'h55}) begin
            bad++;
            $display("[TB] FAIL wr_issue: got req=%b wr=%b rd=%b addr=%h wdata=%h, want 1 1 0 4 00000055",
                     ch_req, ch_write, ch_read, ch_addr, ch_wdata);
        end
        tick();
        total++;
        if ({m0_done, m0_err, m0_rdata, m1_done, ch_req} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wr_done: got d0=%b e0=%b r0=%h d1=%b chreq=%b, want 1 0 0 0 0",
                     m0_done, m0_err, m0_rdata, m1_done, ch_req);
        end
        m0_req = 1'b0;
        tick();
        total++;
        if ({busy, m0_done} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL wr_after: got busy=%b d0=%b, want 0 0", busy, m0_done);
        end
    endtask

    task automatic test_read_wait();
        int  n_read = 0;
        bit  got = 0;
        bit  addr_ok = 1;
        force_delay = 2;
        force_data_en = 1;
        force_data = 32'hA5;
        m1_write = 1'b0;
        m1_addr  = 4'h8;
        m1_wdata = 32'h1234;
        m1_req   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ch_read) n_read++;
            if (ch_req && ch_addr !== 4'h8) addr_ok = 0;
            if (m1_done) begin
                got = 1;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("[TB] FAIL rd_wait_timeout: got no m1_done in 20 cycles, want done");
        end
        total++;
        if (n_read !== 3) begin
            bad++;
            $display("[TB] FAIL rd_read_cycles: got %0d, want 3", n_read);
        end
        total++;
        if ({m1_rdata, m1_err, m0_done, addr_ok} !== {32'hA5, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL rd_result: got r1=%h e1=%b d0=%b addr_ok=%b, want 000000a5 0 0 1",
                     m1_rdata, m1_err, m0_done, addr_ok);
        end
        m1_req = 1'b0;
        force_data_en = 0;
        tick();
    endtask

    task automatic test_contention();
        int  n_acc = 0;
        int  gap = 0;
        int  win;
        bit  prev = 0;
        pulse_reset();
        force_delay = 0;
        m0_write = 1'b0; m0_addr = 4'h1; m0_wdata = 32'h11;
        m1_write = 1'b0; m1_addr = 4'h2; m1_wdata = 32'h22;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int i = 0; i < 60 && n_acc < 4; i++) begin
            tick();
            if (ch_req && !prev) begin
                win = (ch_addr === 4'h1) ? 0 : (ch_addr === 4'h2) ? 1 : 2;
                total++;
                if (win !== n_acc % 2) begin
                    bad++;
                    $display("[TB] FAIL contend_grant%0d: got requester %0d (addr %h), want %0d",
                             n_acc, win, ch_addr, n_acc % 2);
                end
                if (n_acc > 0) begin
                    total++;
                    if (gap < 2) begin
                        bad++;
                        $display("[TB] FAIL contend_gap%0d: got %0d idle cycles, want >=2", n_acc, gap);
                    end
                end
                n_acc++;
                gap = 0;
            end
            if (!ch_req) gap++;
            if (m0_done && m1_done) begin
                total++;
                bad++;
                $display("[TB] FAIL contend_double_done: got both done, want one");
            end
            prev = ch_req;
        end
        total++;
        if (n_acc !== 4) begin
            bad++;
            $display("[TB] FAIL contend_count: got %0d accesses, want 4", n_acc);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int  n_issue;
        bit  got;
        logic          err_v;
        logic [DW-1:0] rd_v;
        for (int pass = 0; pass < 2; pass++) begin
            n_issue = 0;
            got = 0;
            err_v = 1'bx;
            rd_v = 'x;
            force_delay = (pass == 0) ? 99 : TO - 1;
            force_data_en = 1;
            force_data = 32'hDEADBEEF;
            m0_write = 1'b0;
            m0_addr  = 4'h3;
            m0_req   = 1'b1;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (ch_req) n_issue++;
                if (m0_done) begin
                    got = 1;
                    err_v = m0_err;
                    rd_v = m0_rdata;
                    break;
                end
            end
            m0_req = 1'b0;
            total++;
            if (!got) begin
                bad++;
                $display("[TB] FAIL tmo%0d_nodone: got no m0_done in 20 cycles, want done", pass);
            end
            total++;
            if (n_issue !== TO) begin
                bad++;
                $display("[TB] FAIL tmo%0d_issue_cycles: got %0d, want %0d", pass, n_issue, TO);
            end
            total++;
            if (pass == 0 && {err_v, rd_v} !== {1'b1, 32'h0}) begin
                bad++;
                $display("[TB] FAIL tmo_abort: got err=%b rdata=%h, want 1 00000000", err_v, rd_v);
            end else if (pass == 1 && {err_v, rd_v} !== {1'b0, 32'hDEADBEEF}) begin
                bad++;
                $display("[TB] FAIL tmo_last_cycle_ready: got err=%b rdata=%h, want 0 deadbeef", err_v, rd_v);
            end
            tick();
        end
        force_data_en = 0;
    endtask

    task automatic test_reset_mid();
        bit prev = 0;
        bit first_seen = 0;
        bit early_m1 = 0;
        int first_win = 2;
        force_delay = 99;
        m1_write = 1'b0;
        m1_addr  = 4'h9;
        m1_req   = 1'b1;
        tick();
        tick();
        total++;
        if (ch_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_in_issue: got ch_req=%b, want 1", ch_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({ch_req, busy, m1_done} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL rstmid_abort: got ch_req=%b busy=%b d1=%b, want 0 0 0", ch_req, busy, m1_done);
        end
        force_delay = 0;
        m0_write = 1'b1;
        m0_addr  = 4'h5;
        m0_wdata = 32'h77;
        m0_req   = 1'b1;
        for (int i = 0; i < 40 && (m0_req || m1_req); i++) begin
            tick();
            if (ch_req && !prev && !first_seen) begin
                first_seen = 1;
                first_win = (ch_addr === 4'h5) ? 0 : 1;
            end
            if (m1_done && m0_req) early_m1 = 1;
            if (m0_done) m0_req = 1'b0;
            if (m1_done) m1_req = 1'b0;
            prev = ch_req;
        end
        total++;
        if ({first_win != 0, early_m1} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rstmid_order: got first=%0d early_m1_done=%b, want 0 0", first_win, early_m1);
        end
        total++;
        if ({m0_req, m1_req} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rstmid_drain: got pending m0=%b m1=%b, want both served", m0_req, m1_req);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
    endtask

    task automatic test_field_change();
        bit got = 0;
        bit stable = 1;
        int n_issue = 0;
        logic [DW-1:0] rd_v = 'x;
        force_delay = 2;
        force_data_en = 1;
        force_data = 32'h0BADF00D;
        m0_write = 1'b0;
        m0_addr  = 4'h4;
        m0_wdata = 32'h0;
        m0_req   = 1'b1;
        tick();
        m0_addr  = 4'hC;
        m0_write = 1'b1;
        m0_wdata = 32'hFFFF;
        if (ch_req) n_issue++;
        if (!(ch_req && ch_read && ch_addr === 4'h4)) stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (m0_done) begin
                got = 1;
                rd_v = m0_rdata;
                break;
            end
            tick();
            if (ch_req) begin
                n_issue++;
                if (!(ch_read && ch_addr === 4'h4)) stable = 0;
            end
        end
        m0_req = 1'b0;
        total++;
        if ({got, stable} !== 2'b11 || n_issue !== 3) begin
            bad++;
            $display("[TB] FAIL fieldchg_stable: got done=%b stable=%b issue=%0d, want 1 1 3", got, stable, n_issue);
        end
        total++;
        if (rd_v !== 32'h0BADF00D) begin
            bad++;
            $display("[TB] FAIL fieldchg_rdata: got %h, want 0badf00d", rd_v);
        end
        force_data_en = 0;
        tick();
    endtask

    // Transaction-level model: pick a winner from the requests seen at grant, predict outcome from the channel delay.
    task automatic test_random(input int n_acc);
        int   acc = 0;
        int   guard = 0;
        int   issue_n = 0;
        int   e_issue;
        bit   in_acc = 0;
        bit   mdl_last = 1;
        bit   win = 0;
        bit   r0, r1;
        bit   hold0 = 0, hold1 = 0;
        logic e_write = 1'b0;
        logic e_err;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_wdata = '0;
        logic [DW-1:0] e_rdata;
        pulse_reset();
        noise = 1;
        force_delay = -1;
        force_data_en = 0;
        while (acc < n_acc && guard < 20 * n_acc + 100) begin
            if (!m0_req && !hold0 && $urandom_range(0, 2) == 0) begin
                m0_write = 1'($urandom);
                m0_addr  = AW'($urandom);
                m0_wdata = $urandom;
                m0_req   = 1'b1;
            end
            if (!m1_req && !hold1 && $urandom_range(0, 2) == 0) begin
                m1_write = 1'($urandom);
                m1_addr  = AW'($urandom);
                m1_wdata = $urandom;
                m1_req   = 1'b1;
            end
            hold0 = 0;
            hold1 = 0;
            r0 = m0_req;
            r1 = m1_req;
            tick();
            guard++;
            if (ch_req && !in_acc) begin
                in_acc = 1;
                issue_n = 0;
                total++;
                if (!(r0 || r1)) begin
                    bad++;
                    $display("[TB] FAIL rnd_spurious_grant: got ch_req=1, want 0 with no request");
                end
                win     = (r0 && r1) ? ~mdl_last : r1;
                e_write = win ? m1_write : m0_write;
                e_addr  = win ? m1_addr : m0_addr;
                e_wdata = win ? m1_wdata : m0_wdata;
            end
            if (ch_req) begin
                issue_n++;
                total++;
                if ({ch_write, ch_read, ch_addr, ch_wdata} !== {e_write, ~e_write, e_addr, e_wdata}) begin
                    bad++;
                    $display("[TB] FAIL rnd_ch_fields: got wr=%b rd=%b addr=%h wdata=%h, want %b %b %h %h",
                             ch_write, ch_read, ch_addr, ch_wdata, e_write, ~e_write, e_addr, e_wdata);
                end
            end
            if (m0_done || m1_done) begin
                e_err   = (chan_delay >= TO);
                e_rdata = (e_err || e_write) ? '0 : chan_data;
                e_issue = e_err ? TO : chan_delay + 1;
                total++;
                if (!in_acc || {m0_done, m1_done} !== (win ? 2'b01 : 2'b10)) begin
                    bad++;
                    $display("[TB] FAIL rnd_done_owner: got d0=%b d1=%b active=%b, want requester %0d",
                             m0_done, m1_done, in_acc, win);
                end
                total++;
                if ((win ? {m1_err, m1_rdata} : {m0_err, m0_rdata}) !== {e_err, e_rdata}) begin
                    bad++;
                    $display("[TB] FAIL rnd_result: got e0=%b r0=%h e1=%b r1=%h, want err=%b rdata=%h on m%0d",
                             m0_err, m0_rdata, m1_err, m1_rdata, e_err, e_rdata, win);
                end
                total++;
                if (issue_n !== e_issue) begin
                    bad++;
                    $display("[TB] FAIL rnd_issue_len: got %0d, want %0d", issue_n, e_issue);
                end
                total++;
                if ((win ? {m0_err, m0_rdata} : {m1_err, m1_rdata}) !== '0) begin
                    bad++;
                    $display("[TB] FAIL rnd_loser_quiet: got e0=%b r0=%h e1=%b r1=%h, want loser 0",
                             m0_err, m0_rdata, m1_err, m1_rdata);
                end
                if (win) begin
                    m1_req = 1'b0;
                    hold1 = 1;
                end else begin
                    m0_req = 1'b0;
                    hold0 = 1;
                end
                mdl_last = win;
                in_acc = 0;
                acc++;
            end else begin
                total++;
                if ({m0_err, m0_rdata, m1_err, m1_rdata} !== '0) begin
                    bad++;
                    $display("[TB] FAIL rnd_idle_outputs: got e0=%b r0=%h e1=%b r1=%h, want 0",
                             m0_err, m0_rdata, m1_err, m1_rdata);
                end
            end
            total++;
            if (busy !== (ch_req || m0_done || m1_done)) begin
                bad++;
                $display("[TB] FAIL rnd_busy: got %b, want %b", busy, ch_req || m0_done || m1_done);
            end
        end
        total++;
        if (acc !== n_acc) begin
            bad++;
            $display("[TB] FAIL rnd_stall: got %0d accesses, want %0d", acc, n_acc);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        noise = 0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_field_change();
        test_random(150);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
